// File: rtl/joypad_port.sv
// NES-style controller port at 4016/4017: keyboard make/break events drive the
// eight button states, which the CPU latches with a strobe write and shifts out serially.
module joypad_port #(
  parameter logic [7:0] KEY_A      = 8'h0E,
  parameter logic [7:0] KEY_B      = 8'h0D,
  parameter logic [7:0] KEY_SELECT = 8'h2C,
  parameter logic [7:0] KEY_START  = 8'h28,
  parameter logic [7:0] KEY_UP     = 8'h1A,
  parameter logic [7:0] KEY_DOWN   = 8'h16,
  parameter logic [7:0] KEY_LEFT   = 8'h04,
  parameter logic [7:0] KEY_RIGHT  = 8'h07
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_rnw,
  input  logic        bus_en,
  output logic [7:0]  cpu_rd_data,
  output logic        port_sel,
  input  logic [7:0]  keycode,
  input  logic        keypress,
  input  logic        key_evt,
  output logic [7:0]  keystates
);

  localparam logic [15:0] ADDR_PAD1 = 16'h4016;
  localparam logic [15:0] ADDR_PAD2 = 16'h4017;

  logic [7:0] key_hit;
  logic [7:0] shift_q;
  logic       strobe_q;
  logic       sel_pad1;
  logic       sel_pad2;
  logic       rd_pad1;
  logic       rd_pad2;
  logic       wr_pad1;
  logic       unused_data;

  assign sel_pad1 = (cpu_addr == ADDR_PAD1);
  assign sel_pad2 = (cpu_addr == ADDR_PAD2);
  assign port_sel = sel_pad1 | sel_pad2;

  assign rd_pad1 = bus_en &  cpu_rnw & sel_pad1;
  assign rd_pad2 = bus_en &  cpu_rnw & sel_pad2;
  assign wr_pad1 = bus_en & ~cpu_rnw & sel_pad1;

  // Only bit 0 of a strobe write is meaningful.
  assign unused_data = ^cpu_data_in[7:1];

  assign key_hit[0] = (keycode == KEY_A);
  assign key_hit[1] = (keycode == KEY_B);
  assign key_hit[2] = (keycode == KEY_SELECT);
  assign key_hit[3] = (keycode == KEY_START);
  assign key_hit[4] = (keycode == KEY_UP);
  assign key_hit[5] = (keycode == KEY_DOWN);
  assign key_hit[6] = (keycode == KEY_LEFT);
  assign key_hit[7] = (keycode == KEY_RIGHT);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      keystates <= 8'h00;
    end else if (key_evt) begin
      keystates <= (keystates & ~key_hit) | (key_hit & {8{keypress}});
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      strobe_q <= 1'b0;
    end else if (wr_pad1) begin
      strobe_q <= cpu_data_in[0];
    end
  end

  // Reload uses the registered strobe, so the edge on which strobe falls still
  // captures a final snapshot; reads during strobe never shift.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      shift_q <= 8'hFF;
    end else if (strobe_q) begin
      shift_q <= keystates;
    end else if (rd_pad1) begin
      shift_q <= {1'b1, shift_q[7:1]};
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cpu_rd_data <= 8'h40;
    end else if (rd_pad1) begin
      cpu_rd_data <= {7'b0100000, (strobe_q ? keystates[0] : shift_q[0])};
    end else if (rd_pad2) begin
      cpu_rd_data <= 8'h40;
    end
  end

endmodule

// File: tb/tb_joypad_port.sv
// Directed bench for joypad_port: read results go through an expected queue,
// state checks are immediate assertions against constants.
module tb_joypad_port;

  logic        clk;
  logic        nreset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic        cpu_rnw;
  logic        bus_en;
  logic [7:0]  cpu_rd_data;
  logic        port_sel;
  logic [7:0]  keycode;
  logic        keypress;
  logic        key_evt;
  logic [7:0]  keystates;

  int errors;
  int checks;
  logic [7:0] exp_q[$];

  joypad_port dut (
    .clk         (clk),
    .nreset      (nreset),
    .cpu_addr    (cpu_addr),
    .cpu_data_in (cpu_data_in),
    .cpu_rnw     (cpu_rnw),
    .bus_en      (bus_en),
    .cpu_rd_data (cpu_rd_data),
    .port_sel    (port_sel),
    .keycode     (keycode),
    .keypress    (keypress),
    .key_evt     (key_evt),
    .keystates   (keystates)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle, inputs change on the falling edge, results seen on the next one.
  task automatic bus_cycle(input logic [15:0] addr, input logic [7:0] data,
                           input logic rnw, input logic en);
    @(negedge clk);
    cpu_addr    = addr;
    cpu_data_in = data;
    cpu_rnw     = rnw;
    bus_en      = en;
    @(negedge clk);
    bus_en      = 1'b0;
    cpu_rnw     = 1'b1;
    cpu_addr    = 16'h0000;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] data);
    bus_cycle(addr, data, 1'b0, 1'b1);
  endtask

  task automatic rd(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    logic [7:0] e;
    exp_q.push_back(exp);
    bus_cycle(addr, 8'h00, 1'b1, 1'b1);
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, cpu_rd_data, e);
    end
  endtask

  task automatic key(input logic [7:0] code, input logic press);
    @(negedge clk);
    keycode  = code;
    keypress = press;
    key_evt  = 1'b1;
    @(negedge clk);
    key_evt  = 1'b0;
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    nreset      = 1'b0;
    cpu_addr    = 16'h0000;
    cpu_data_in = 8'h00;
    cpu_rnw     = 1'b1;
    bus_en      = 1'b0;
    keycode     = 8'h00;
    keypress    = 1'b0;
    key_evt     = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("reset_keystates", keystates, 8'h00);
    chk("reset_rd_data", cpu_rd_data, 8'h40);
    chk("port_sel_0000", {7'b0, port_sel}, 8'h00);
    nreset = 1'b1;

    rd("first_read_after_reset", 16'h4016, 8'h41);
    rd("read_4017", 16'h4017, 8'h40);
    key(8'h55, 1'b1);
    chk("unmapped_key_ignored", keystates, 8'h00);

    // press A (K) and Start (Enter), strobe, shift all eight out
    key(8'h0E, 1'b1);
    key(8'h28, 1'b1);
    chk("keystates_a_start", keystates, 8'h09);
    wr(16'h4016, 8'h01);
    wr(16'h4016, 8'h00);
    foreach (exp_q[i]) exp_q.delete(i);
    rd("serial_bit0", 16'h4016, 8'h41);
    rd("serial_bit1", 16'h4016, 8'h40);
    rd("serial_bit2", 16'h4016, 8'h40);
    rd("serial_bit3", 16'h4016, 8'h41);
    rd("serial_bit4", 16'h4016, 8'h40);
    rd("serial_bit5", 16'h4016, 8'h40);
    rd("serial_bit6", 16'h4016, 8'h40);
    rd("serial_bit7", 16'h4016, 8'h40);
    rd("drained_read9", 16'h4016, 8'h41);
    rd("drained_read10", 16'h4016, 8'h41);
    rd("pad2_after_drain", 16'h4017, 8'h40);

    // idle / foreign-address cycles must not disturb shift or read data
    wr(16'h4016, 8'h01);
    wr(16'h4016, 8'h00);
    rd("idle_setup_bit0", 16'h4016, 8'h41);
    bus_cycle(16'h4016, 8'h00, 1'b1, 1'b0);
    chk("idle_read_rd_data", cpu_rd_data, 8'h41);
    bus_cycle(16'h4016, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    cpu_addr = 16'h4015;
    #1;
    chk("port_sel_4015", {7'b0, port_sel}, 8'h00);
    cpu_addr = 16'h4017;
    #1;
    chk("port_sel_4017", {7'b0, port_sel}, 8'h01);
    bus_cycle(16'h4015, 8'h00, 1'b1, 1'b1);
    chk("read_4015_rd_data", cpu_rd_data, 8'h41);
    wr(16'h4015, 8'h01);
    wr(16'h4017, 8'h01);
    rd("idle_resume_bit1", 16'h4016, 8'h40);
    rd("idle_resume_bit2", 16'h4016, 8'h40);
    rd("idle_resume_bit3", 16'h4016, 8'h41);

    // strobe held high: reads follow live A, no shifting
    wr(16'h4016, 8'h01);
    rd("strobe_a_held", 16'h4016, 8'h41);
    key(8'h0E, 1'b0);
    rd("strobe_a_released", 16'h4016, 8'h40);
    key(8'h0E, 1'b1);
    rd("strobe_a_pressed", 16'h4016, 8'h41);
    wr(16'h4016, 8'h00);
    rd("post_strobe_bit0", 16'h4016, 8'h41);
    rd("post_strobe_bit1", 16'h4016, 8'h40);

    // opposing directions both pass through
    key(8'h1A, 1'b1);
    key(8'h16, 1'b1);
    chk("keystates_up_down", keystates, 8'h39);
    wr(16'h4016, 8'h01);
    wr(16'h4016, 8'h00);
    rd("updown_bit0", 16'h4016, 8'h41);
    rd("updown_bit1", 16'h4016, 8'h40);
    rd("updown_bit2", 16'h4016, 8'h40);
    rd("updown_bit3", 16'h4016, 8'h41);
    rd("updown_bit4", 16'h4016, 8'h41);
    rd("updown_bit5", 16'h4016, 8'h41);
    rd("updown_bit6", 16'h4016, 8'h40);
    key(8'h1A, 1'b0);
    chk("keystates_up_released", keystates, 8'h29);

    // asynchronous reset in the middle of a read sequence
    wr(16'h4016, 8'h01);
    wr(16'h4016, 8'h00);
    rd("prereset_bit0", 16'h4016, 8'h41);
    rd("prereset_bit1", 16'h4016, 8'h40);
    rd("prereset_bit2", 16'h4016, 8'h40);
    @(negedge clk);
    #2;
    nreset = 1'b0;
    #1;
    chk("async_reset_keystates", keystates, 8'h00);
    chk("async_reset_rd_data", cpu_rd_data, 8'h40);
    @(negedge clk);
    nreset = 1'b1;
    rd("read_after_async_reset", 16'h4016, 8'h41);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL leftover_expected observed=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/joypad_port.md
JOYPAD_PORT -- requirements
Module: joypad_port

Interface
REQ-001 The block SHALL provide the following parameters (name, default, meaning):
- KEY_A, 8'h0E, keycode for button A (bit 0)
- KEY_B, 8'h0D, keycode for button B (bit 1)
- KEY_SELECT, 8'h2C, keycode for Select (bit 2)
- KEY_START, 8'h28, keycode for Start (bit 3)
- KEY_UP, 8'h1A, keycode for Up (bit 4)
- KEY_DOWN, 8'h16, keycode for Down (bit 5)
- KEY_LEFT, 8'h04, keycode for Left (bit 6)
- KEY_RIGHT, 8'h07, keycode for Right (bit 7)

REQ-002 The block SHALL provide the following ports (name, direction, width, meaning):
- clk, in, 1, single system clock; all state updates on its rising edge
- nreset, in, 1, asynchronous active-low reset
- cpu_addr, in, 16, CPU address bus
- cpu_data_in, in, 8, CPU write data
- cpu_rnw, in, 1, 1 = read, 0 = write
- bus_en, in, 1, one-clk qualifier marking a valid CPU bus cycle
- cpu_rd_data, out, 8, registered read data to CPU
- port_sel, out, 1, combinational; high when cpu_addr is 16'h4016 or 16'h4017
- keycode, in, 8, key identifier of a key event
- keypress, in, 1, 1 = key make, 0 = key break
- key_evt, in, 1, one-clk strobe qualifying keycode/keypress
- keystates, out, 8, current button states in NES order (bit0 A ... bit7 Right)

Function
REQ-003 On key_evt=1, if keycode equals the parameter for bit i, keystates[i] SHALL take the value of keypress at the next edge; non-matching keycodes SHALL be ignored.
REQ-004 Opposing directions (Up+Down, Left+Right) SHALL NOT be filtered.
REQ-005 A write cycle to 16'h4016 (bus_en=1, cpu_rnw=0) SHALL load strobe from cpu_data_in[0].
REQ-006 Writes to any other address, including 16'h4017, SHALL be ignored.
REQ-007 While strobe=1, the 8-bit shift register SHALL reload from keystates every clk. The reload SHALL use the registered keystates, i.e. the value before any same-cycle key_evt update.
REQ-008 When strobe falls, the shift register SHALL hold the snapshot taken on the last cycle strobe was 1.
REQ-009 A read cycle of 16'h4016 with strobe=0 SHALL load cpu_rd_data with {7'b0100000, shift[0]} and shift the register right by one, filling with 1.
REQ-010 A read cycle of 16'h4016 with strobe=1 SHALL return {7'b0100000, keystates[0]} and SHALL NOT shift.
REQ-011 After 8 shifting reads, every further read SHALL return 8'h41 until the next reload.
REQ-012 A read cycle of 16'h4017 SHALL return 8'h40 (no second controller) with no state change.
REQ-013 Read latency: cpu_rd_data SHALL be valid on the edge ending the bus_en cycle and SHALL hold until the next matching read.
REQ-014 Cycles with bus_en=0, or with an address not selected by port_sel, SHALL change neither the shift register nor cpu_rd_data.
REQ-015 A write to 16'h4016 and a key_evt in the same cycle SHALL both take effect.
REQ-016 A read of 16'h4016 in the same cycle strobe is being set by a prior write SHALL use the strobe value registered before that cycle.

Reset
REQ-017 nreset=0 SHALL asynchronously set keystates=8'h00, shift register=8'hFF, strobe=0 and cpu_rd_data=8'h40, regardless of any operation in progress.
REQ-018 After nreset deasserts, the first read of 16'h4016 without an intervening strobe SHALL return 8'h41.

Verification
REQ-019 Press K (8'h0E) and Enter (8'h28); write 4016=1 then 4016=0; issue 8 reads of 4016 -> read bit0 sequence 1,0,0,1,0,0,0,0; keystates=8'h09.
REQ-020 Continue reading 4016 after the 8 reads above -> 8'h41 on every read; reads of 4017 -> 8'h40.
REQ-021 Keep strobe=1 and read 4016 three times while toggling A -> each read returns the current A state; no shift occurs.
REQ-022 Press W then S (both held), strobe, and read -> bits 4 and 5 are both 1; release W (break event) -> keystates[4]=0.
REQ-023 Assert nreset after 3 reads -> keystates=00 and cpu_rd_data=40 immediately; the next read returns 41.
REQ-024 Issue reads and writes with bus_en=0, and to address 4015 -> no change to the shift register or cpu_rd_data; port_sel=0 for 4015.
